// File: rtl/ram_buff_sched_if.sv
// ============================================================================
// Module   : ram_buff_sched_if
// Brief    : Descriptor, buffer-control and status bundle for ram_buff_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_buff_sched_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [ADDR_WIDTH-1:0] cmd_start_addr;
  logic [7:0]            cmd_row_num;
  logic                  cmd_dir;
  logic [3:0]            cmd_start_byte;
  logic [3:0]            cmd_end_byte;
  logic                  ram_buff_idle;
  logic                  sched_flush;
  logic                  ctrl_ram_buff_vld;
  logic [ADDR_WIDTH-1:0] ctrl_ram_buff_start_addr;
  logic [3:0]            ctrl_ram_buff_ent_num;
  logic [4:0]            ctrl_ram_buff_ent_rng;
  logic [3:0]            ctrl_ram_buff_start_byte;
  logic [3:0]            ctrl_ram_buff_end_byte;
  logic                  sched_busy;
  logic                  sched_done;

  modport master (
    output cmd_vld, cmd_start_addr, cmd_row_num, cmd_dir, cmd_start_byte,
           cmd_end_byte, ram_buff_idle, sched_flush,
    input  cmd_rdy, ctrl_ram_buff_vld, ctrl_ram_buff_start_addr,
           ctrl_ram_buff_ent_num, ctrl_ram_buff_ent_rng,
           ctrl_ram_buff_start_byte, ctrl_ram_buff_end_byte,
           sched_busy, sched_done
  );

  modport slave (
    input  cmd_vld, cmd_start_addr, cmd_row_num, cmd_dir, cmd_start_byte,
           cmd_end_byte, ram_buff_idle, sched_flush,
    output cmd_rdy, ctrl_ram_buff_vld, ctrl_ram_buff_start_addr,
           ctrl_ram_buff_ent_num, ctrl_ram_buff_ent_rng,
           ctrl_ram_buff_start_byte, ctrl_ram_buff_end_byte,
           sched_busy, sched_done
  );
endinterface

`default_nettype wire

// File: rtl/ram_buff_sched.sv
// ============================================================================
// Module   : ram_buff_sched
// Brief    : Splits row-load descriptors into ENT_NUM-row chunks for ram_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_buff_sched #(
  parameter int ENT_NUM    = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  ram_buff_sched_if.slave  bus
);

  localparam logic [7:0] c_chunk_max = 8'(ENT_NUM);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_HOLD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [7:0]            r_rem;
  logic [7:0]            w_rem_nxt;
  logic                  r_dir;
  logic                  w_dir_nxt;
  logic [3:0]            r_sb;
  logic [3:0]            w_sb_nxt;
  logic [3:0]            r_eb;
  logic [3:0]            w_eb_nxt;
  logic                  r_first;
  logic                  w_first_nxt;

  logic [7:0]            w_chunk_cur;
  logic [7:0]            w_chunk_nxt;
  logic [7:0]            w_chunk_nxt_m1;
  logic [3:0]            w_ent_nxt;
  logic [4:0]            w_rng_mag;
  logic [4:0]            w_rng_nxt;
  logic                  w_last_nxt;

  logic                  r_cmd_rdy;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_ctrl_addr;
  logic [3:0]            r_ctrl_ent;
  logic [4:0]            r_ctrl_rng;
  logic [3:0]            r_ctrl_sb;
  logic [3:0]            r_ctrl_eb;

  function automatic logic [7:0] f_chunk(input logic [7:0] rem);
    return (rem >= c_chunk_max) ? c_chunk_max : rem;
  endfunction

  assign w_chunk_cur = f_chunk(r_rem);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_dir_nxt   = r_dir;
    w_sb_nxt    = r_sb;
    w_eb_nxt    = r_eb;
    w_first_nxt = r_first;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_vld && r_cmd_rdy) begin
          w_addr_nxt  = bus.cmd_start_addr;
          w_rem_nxt   = bus.cmd_row_num;
          w_dir_nxt   = bus.cmd_dir;
          w_sb_nxt    = bus.cmd_start_byte;
          w_eb_nxt    = bus.cmd_end_byte;
          w_first_nxt = 1'b1;
          w_state_nxt = (bus.cmd_row_num == 8'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_first_nxt = 1'b0;
        w_state_nxt = ST_HOLD;
      end
      // The buffer still reports idle for one cycle after a pulse.
      ST_HOLD: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.ram_buff_idle) begin
          w_rem_nxt   = r_rem - w_chunk_cur;
          w_addr_nxt  = r_dir ? (r_addr - ADDR_WIDTH'(w_chunk_cur))
                              : (r_addr + ADDR_WIDTH'(w_chunk_cur));
          w_state_nxt = (w_rem_nxt == 8'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    if (bus.sched_flush) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Chunk fields are derived from next-state values so they register together with vld.
  assign w_chunk_nxt    = f_chunk(w_rem_nxt);
  assign w_chunk_nxt_m1 = w_chunk_nxt - 8'd1;
  assign w_ent_nxt      = w_chunk_nxt_m1[3:0];
  assign w_rng_mag      = {1'b0, w_ent_nxt};
  assign w_rng_nxt      = w_dir_nxt ? (5'd0 - w_rng_mag) : w_rng_mag;
  assign w_last_nxt     = (w_rem_nxt <= c_chunk_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rem       <= 8'd0;
      r_dir       <= 1'b0;
      r_sb        <= 4'h0;
      r_eb        <= 4'h0;
      r_first     <= 1'b0;
      r_cmd_rdy   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vld       <= 1'b0;
      r_ctrl_addr <= '0;
      r_ctrl_ent  <= 4'h0;
      r_ctrl_rng  <= 5'h00;
      r_ctrl_sb   <= 4'h0;
      r_ctrl_eb   <= 4'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_rem     <= w_rem_nxt;
      r_dir     <= w_dir_nxt;
      r_sb      <= w_sb_nxt;
      r_eb      <= w_eb_nxt;
      r_first   <= w_first_nxt;
      r_cmd_rdy <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      r_vld     <= (w_state_nxt == ST_ISSUE);
      if (w_state_nxt == ST_ISSUE) begin
        r_ctrl_addr <= w_addr_nxt;
        r_ctrl_ent  <= w_ent_nxt;
        r_ctrl_rng  <= w_rng_nxt;
        r_ctrl_sb   <= w_first_nxt ? w_sb_nxt : 4'h0;
        r_ctrl_eb   <= w_last_nxt ? w_eb_nxt : 4'hF;
      end
    end
  end

  assign bus.cmd_rdy                  = r_cmd_rdy;
  assign bus.sched_busy               = r_busy;
  assign bus.sched_done               = r_done;
  assign bus.ctrl_ram_buff_vld        = r_vld;
  assign bus.ctrl_ram_buff_start_addr = r_ctrl_addr;
  assign bus.ctrl_ram_buff_ent_num    = r_ctrl_ent;
  assign bus.ctrl_ram_buff_ent_rng    = r_ctrl_rng;
  assign bus.ctrl_ram_buff_start_byte = r_ctrl_sb;
  assign bus.ctrl_ram_buff_end_byte   = r_ctrl_eb;

endmodule

`default_nettype wire

// File: tb/tb_ram_buff_sched.sv
// ============================================================================
// Module   : tb_ram_buff_sched
// Brief    : Scoreboard bench for ram_buff_sched with a ram_buffer idle model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_buff_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_buff_sched_if #(.ADDR_WIDTH(8)) bus ();

  ram_buff_sched #(.ENT_NUM(16), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] en;
    logic [4:0] rng;
    logic [3:0] sb;
    logic [3:0] eb;
  } pulse_t;

  pulse_t exp_q[$];
  int     pulse_cyc_q[$];
  pulse_t m_got;
  pulse_t m_exp;

  int n_cmp          = 0;
  int n_err          = 0;
  int cyc            = 0;
  int pulse_cnt      = 0;
  int done_cnt       = 0;
  int done_cyc       = -1;
  int last_pulse_cyc = -100;
  int idle_cnt       = 0;
  int idle_lat       = 5;
  bit idle_low       = 1'b0;

  always @(posedge clk) cyc++;

  // ram_buffer stand-in: drops idle on each pulse, returns idle_lat cycles later.
  always @(negedge clk) begin
    if (!rst_n)                     idle_cnt = 0;
    else if (bus.ctrl_ram_buff_vld) idle_cnt = idle_lat;
    else if (idle_cnt > 0)          idle_cnt--;
  end
  assign bus.ram_buff_idle = (idle_cnt == 0) && !idle_low;

  always @(negedge clk) begin
    if (rst_n && bus.ctrl_ram_buff_vld) begin
      m_got = {bus.ctrl_ram_buff_start_addr, bus.ctrl_ram_buff_ent_num,
               bus.ctrl_ram_buff_ent_rng, bus.ctrl_ram_buff_start_byte,
               bus.ctrl_ram_buff_end_byte};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pulse_unexpected: got addr=%h ent=%h rng=%h sb=%h eb=%h, required no pulse",
                 m_got.addr, m_got.en, m_got.rng, m_got.sb, m_got.eb);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_got !== m_exp) begin
          n_err++;
          $display("FAIL pulse_fields: got addr=%h ent=%h rng=%h sb=%h eb=%h, required addr=%h ent=%h rng=%h sb=%h eb=%h",
                   m_got.addr, m_got.en, m_got.rng, m_got.sb, m_got.eb,
                   m_exp.addr, m_exp.en, m_exp.rng, m_exp.sb, m_exp.eb);
        end
      end
      n_cmp++;
      if (cyc == last_pulse_cyc + 1) begin
        n_err++;
        $display("FAIL pulse_spacing: pulses at cycles %0d and %0d, required non-consecutive",
                 last_pulse_cyc, cyc);
      end
      last_pulse_cyc = cyc;
      pulse_cyc_q.push_back(cyc);
      pulse_cnt++;
    end
    if (rst_n && bus.sched_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic void push_exp(input logic [7:0] a, input logic [3:0] e,
                                   input logic [4:0] r, input logic [3:0] sb,
                                   input logic [3:0] eb);
    exp_q.push_back({a, e, r, sb, eb});
  endfunction

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_desc(input logic [7:0] a, input logic [7:0] rows, input logic d,
                           input logic [3:0] sb, input logic [3:0] eb, output int acc);
    int n = 0;
    while (bus.cmd_rdy !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    n_cmp++;
    if (bus.cmd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout: cmd_rdy=%b, required 1", bus.cmd_rdy);
    end
    bus.cmd_vld        = 1'b1;
    bus.cmd_start_addr = a;
    bus.cmd_row_num    = rows;
    bus.cmd_dir        = d;
    bus.cmd_start_byte = sb;
    bus.cmd_end_byte   = eb;
    acc = cyc;
    tick(1);
    bus.cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      tick(1);
      n++;
    end
    tick(1);
    n_cmp++;
    if (done_cnt != target) begin
      n_err++;
      $display("FAIL %s_done_count: got %0d, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    bus.cmd_vld = 1'b0; bus.cmd_start_addr = 8'h00; bus.cmd_row_num = 8'h00;
    bus.cmd_dir = 1'b0; bus.cmd_start_byte = 4'h0; bus.cmd_end_byte = 4'h0;
    bus.sched_flush = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    n_cmp++; if (bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL reset_cmd_rdy: got %b, required 1", bus.cmd_rdy); end
    n_cmp++; if (bus.sched_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", bus.sched_busy); end
    n_cmp++; if (bus.sched_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", bus.sched_done); end
    n_cmp++; if (bus.ctrl_ram_buff_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b, required 0", bus.ctrl_ram_buff_vld); end
    n_cmp++;
    if ({bus.ctrl_ram_buff_start_addr, bus.ctrl_ram_buff_ent_num, bus.ctrl_ram_buff_ent_rng,
         bus.ctrl_ram_buff_start_byte, bus.ctrl_ram_buff_end_byte} !== 25'h0) begin
      n_err++;
      $display("FAIL reset_fields: got addr=%h ent=%h rng=%h, required all zero",
               bus.ctrl_ram_buff_start_addr, bus.ctrl_ram_buff_ent_num, bus.ctrl_ram_buff_ent_rng);
    end
  endtask

  task automatic test_ascending();
    int acc;
    int bd = done_cnt;
    int bp = pulse_cnt;
    idle_lat = 5;
    pulse_cyc_q.delete();
    push_exp(8'h10, 4'd15, 5'h0F, 4'h3, 4'hF);
    push_exp(8'h20, 4'd15, 5'h0F, 4'h0, 4'hF);
    push_exp(8'h30, 4'd7,  5'h07, 4'h0, 4'h9);
    send_desc(8'h10, 8'd40, 1'b0, 4'h3, 4'h9, acc);
    n_cmp++;
    if ({bus.ctrl_ram_buff_vld, bus.cmd_rdy, bus.sched_busy} !== 3'b101) begin
      n_err++;
      $display("FAIL asc_after_accept: vld/rdy/busy=%b%b%b, required 101",
               bus.ctrl_ram_buff_vld, bus.cmd_rdy, bus.sched_busy);
    end
    wait_done(bd + 1, "asc");
    tick(3);
    n_cmp++; if (pulse_cnt - bp != 3) begin n_err++; $display("FAIL asc_pulse_count: got %0d, required 3", pulse_cnt - bp); end
    n_cmp++; if (pulse_cyc_q[0] != acc + 1) begin n_err++; $display("FAIL asc_first_latency: got cycle %0d, required %0d", pulse_cyc_q[0], acc + 1); end
    n_cmp++; if (pulse_cyc_q[1] - pulse_cyc_q[0] != 6) begin n_err++; $display("FAIL asc_issue_gap: got %0d, required 6", pulse_cyc_q[1] - pulse_cyc_q[0]); end
    n_cmp++; if (done_cnt != bd + 1) begin n_err++; $display("FAIL asc_single_done: got %0d, required %0d", done_cnt, bd + 1); end
    n_cmp++; if (bus.sched_busy !== 1'b0 || bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL asc_end_state: busy=%b rdy=%b, required 0 1", bus.sched_busy, bus.cmd_rdy); end
  endtask

  task automatic test_descending();
    int acc;
    int bd = done_cnt;
    pulse_cyc_q.delete();
    push_exp(8'h05, 4'd15, 5'h11, 4'h2, 4'hF);
    push_exp(8'hF5, 4'd3,  5'h1D, 4'h0, 4'hC);
    send_desc(8'h05, 8'd20, 1'b1, 4'h2, 4'hC, acc);
    wait_done(bd + 1, "desc");
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL desc_pending: got %0d pulses outstanding, required 0", exp_q.size()); end
    n_cmp++; if (done_cyc - pulse_cyc_q[1] != 6) begin n_err++; $display("FAIL desc_done_latency: got %0d, required 6", done_cyc - pulse_cyc_q[1]); end
  endtask

  task automatic test_zero_rows();
    int acc;
    int acc2;
    int bd = done_cnt;
    int bp = pulse_cnt;
    send_desc(8'h33, 8'd0, 1'b0, 4'h1, 4'h2, acc);
    n_cmp++; if (bus.sched_done !== 1'b1 || bus.cmd_rdy !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: done=%b rdy=%b, required 1 0", bus.sched_done, bus.cmd_rdy); end
    tick(1);
    n_cmp++; if (bus.cmd_rdy !== 1'b1 || bus.sched_done !== 1'b0) begin n_err++; $display("FAIL zero_rdy_return: rdy=%b done=%b, required 1 0", bus.cmd_rdy, bus.sched_done); end
    send_desc(8'h44, 8'd0, 1'b1, 4'h0, 4'h0, acc2);
    n_cmp++; if (acc2 != acc + 2) begin n_err++; $display("FAIL back_to_back_accept: got cycle %0d, required %0d", acc2, acc + 2); end
    wait_done(bd + 2, "zero");
    n_cmp++; if (pulse_cnt != bp) begin n_err++; $display("FAIL zero_no_pulse: got %0d pulses, required 0", pulse_cnt - bp); end
  endtask

  task automatic test_wrap();
    int acc;
    int bd = done_cnt;
    push_exp(8'hF8, 4'd15, 5'h0F, 4'h4, 4'h7);
    send_desc(8'hF8, 8'd16, 1'b0, 4'h4, 4'h7, acc);
    wait_done(bd + 1, "wrap16");
    push_exp(8'hF8, 4'd0, 5'h00, 4'hA, 4'hB);
    send_desc(8'hF8, 8'd1, 1'b0, 4'hA, 4'hB, acc);
    wait_done(bd + 2, "wrap1");
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_pending: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_holdoff();
    int acc;
    int bd = done_cnt;
    idle_lat = 0;
    pulse_cyc_q.delete();
    push_exp(8'h80, 4'd15, 5'h0F, 4'h0, 4'hF);
    push_exp(8'h90, 4'd15, 5'h0F, 4'h0, 4'hF);
    push_exp(8'hA0, 4'd15, 5'h0F, 4'h0, 4'h1);
    send_desc(8'h80, 8'd48, 1'b0, 4'h0, 4'h1, acc);
    wait_done(bd + 1, "holdoff");
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (pulse_cyc_q[i] - pulse_cyc_q[i-1] != 3) begin
        n_err++;
        $display("FAIL holdoff_gap%0d: got %0d, required 3", i, pulse_cyc_q[i] - pulse_cyc_q[i-1]);
      end
    end
    n_cmp++; if (done_cyc - pulse_cyc_q[2] != 3) begin n_err++; $display("FAIL holdoff_done_gap: got %0d, required 3", done_cyc - pulse_cyc_q[2]); end
    idle_lat = 5;
  endtask

  task automatic test_flush();
    int acc;
    int n = 0;
    int bd = done_cnt;
    int bp = pulse_cnt;
    push_exp(8'h10, 4'd15, 5'h0F, 4'h3, 4'hF);
    push_exp(8'h20, 4'd15, 5'h0F, 4'h0, 4'hF);
    push_exp(8'h30, 4'd7,  5'h07, 4'h0, 4'h9);
    send_desc(8'h10, 8'd40, 1'b0, 4'h3, 4'h9, acc);
    while (pulse_cnt < bp + 2 && n < 100) begin tick(1); n++; end
    tick(1);
    bus.sched_flush = 1'b1;
    tick(1);
    bus.sched_flush = 1'b0;
    n_cmp++; if (bus.cmd_rdy !== 1'b1 || bus.sched_busy !== 1'b0) begin n_err++; $display("FAIL flush_idle: rdy=%b busy=%b, required 1 0", bus.cmd_rdy, bus.sched_busy); end
    tick(15);
    n_cmp++; if (pulse_cnt != bp + 2) begin n_err++; $display("FAIL flush_pulses: got %0d, required 2", pulse_cnt - bp); end
    n_cmp++; if (done_cnt != bd) begin n_err++; $display("FAIL flush_no_done: got %0d, required %0d", done_cnt, bd); end
    exp_q.delete();
    bus.cmd_vld = 1'b1; bus.cmd_row_num = 8'd5; bus.sched_flush = 1'b1;
    tick(1);
    bus.cmd_vld = 1'b0; bus.sched_flush = 1'b0;
    n_cmp++; if (bus.sched_busy !== 1'b0 || bus.ctrl_ram_buff_vld !== 1'b0) begin n_err++; $display("FAIL flush_vs_accept: busy=%b vld=%b, required 0 0", bus.sched_busy, bus.ctrl_ram_buff_vld); end
    push_exp(8'h40, 4'd15, 5'h0F, 4'h5, 4'hF);
    push_exp(8'h50, 4'd3,  5'h03, 4'h0, 4'h6);
    send_desc(8'h40, 8'd20, 1'b0, 4'h5, 4'h6, acc);
    wait_done(bd + 1, "post_flush");
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL post_flush_pending: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int acc;
    int n = 0;
    int bd = done_cnt;
    int bp = pulse_cnt;
    push_exp(8'h10, 4'd15, 5'h0F, 4'h3, 4'hF);
    push_exp(8'h20, 4'd15, 5'h0F, 4'h0, 4'hF);
    push_exp(8'h30, 4'd7,  5'h07, 4'h0, 4'h9);
    send_desc(8'h10, 8'd40, 1'b0, 4'h3, 4'h9, acc);
    while (pulse_cnt < bp + 1 && n < 100) begin tick(1); n++; end
    tick(2);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cmd_rdy, bus.sched_busy, bus.sched_done, bus.ctrl_ram_buff_vld} !== 4'b1000) begin
      n_err++;
      $display("FAIL async_reset_status: rdy/busy/done/vld=%b%b%b%b, required 1000",
               bus.cmd_rdy, bus.sched_busy, bus.sched_done, bus.ctrl_ram_buff_vld);
    end
    n_cmp++;
    if ({bus.ctrl_ram_buff_start_addr, bus.ctrl_ram_buff_ent_num, bus.ctrl_ram_buff_ent_rng,
         bus.ctrl_ram_buff_start_byte, bus.ctrl_ram_buff_end_byte} !== 25'h0) begin
      n_err++;
      $display("FAIL async_reset_fields: got addr=%h ent=%h, required zero",
               bus.ctrl_ram_buff_start_addr, bus.ctrl_ram_buff_ent_num);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    n_cmp++; if (done_cnt != bd) begin n_err++; $display("FAIL reset_no_done: got %0d, required %0d", done_cnt, bd); end
    push_exp(8'h22, 4'd2, 5'h1E, 4'h1, 4'h8);
    send_desc(8'h22, 8'd3, 1'b1, 4'h1, 4'h8, acc);
    wait_done(bd + 1, "post_reset");
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL post_reset_pending: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    bus.sched_flush = 1'b0;
    bus.cmd_vld     = 1'b0;
    #2;
    test_reset();
    test_ascending();
    test_descending();
    test_zero_rows();
    test_wrap();
    test_holdoff();
    test_flush();
    test_reset_mid();
    tick(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_pending: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/ram_buff_sched.md
# ram_buff_sched

Sequencer for `ram_buffer`. It accepts one load descriptor per handshake from the MXU command path, covering up to 255 consecutive RAM rows in either direction. It splits each descriptor into chunks of at most ENT_NUM rows and issues one `ctrl_ram_buff_*` configuration pulse per chunk. After each pulse it waits for the buffer to return to idle, then issues the next chunk. It sits between the MXU command queue and `ram_buffer`, and is the only driver of `ram_buffer`'s ctrl inputs.

## Interface
- ENT_NUM, 16, buffer entries per chunk; fixed at 16 because `ent_num` and `ent_rng` widths depend on it.
- ADDR_WIDTH, 8, RAM row address width.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_vld  in  1  descriptor valid.
- cmd_rdy  out  1  descriptor accepted this cycle when `cmd_vld & cmd_rdy`.
- cmd_start_addr  in  8  first RAM row.
- cmd_row_num  in  8  total rows to load; 0 is a legal no-op.
- cmd_dir  in  1  0 = ascending addresses, 1 = descending.
- cmd_start_byte  in  4  byte offset in the first row.
- cmd_end_byte  in  4  last valid byte in the last row.
- ram_buff_idle  in  1  high while the `ram_buffer` FSM is in IDLE.
- sched_flush  in  1  synchronous abort.
- ctrl_ram_buff_vld  out  1  one-cycle configuration pulse.
- ctrl_ram_buff_start_addr  out  8  chunk start row.
- ctrl_ram_buff_ent_num  out  4  chunk rows minus 1.
- ctrl_ram_buff_ent_rng  out  5  signed range: +(rows−1), or −(rows−1) for descending, in two's complement.
- ctrl_ram_buff_start_byte  out  4  `cmd_start_byte` on the first chunk, else 4'h0.
- ctrl_ram_buff_end_byte  out  4  `cmd_end_byte` on the last chunk, else 4'hF.
- sched_busy  out  1  high whenever the FSM is not in IDLE.
- sched_done  out  1  one-cycle pulse when the descriptor completes.

## Operation
- Registers, all captured on accept:
  - `addr_q` (8b)
  - `rem_q` (8b, rows left)
  - `dir_q`
  - `sb_q`, `eb_q`
  - `first_q` (set on accept, cleared after the first issue)
- FSM states:
  - IDLE: `cmd_rdy` = 1.
    - On accept with `cmd_row_num` ≠ 0 → ISSUE.
    - On accept with `cmd_row_num` = 0 → DONE.
  - ISSUE: drive `ctrl_ram_buff_vld` = 1 with chunk fields → HOLD.
  - HOLD: one-cycle holdoff so the buffer can leave IDLE; `ram_buff_idle` is ignored in this state → WAIT.
  - WAIT: when `ram_buff_idle` = 1:
    - subtract the chunk from `rem_q`;
    - add the chunk to `addr_q` (ascending) or subtract it (descending);
    - if the new `rem_q` = 0 → DONE, else → ISSUE.
  - DONE: `sched_done` = 1 → IDLE.
- Chunk computation:
  - `chunk = (rem_q >= 16) ? 16 : rem_q`.
  - `ent_num = chunk − 1`, truncated to 4 bits.
  - `ent_rng = dir_q ? −(chunk−1) : (chunk−1)`, 5-bit two's complement.
  - Last chunk: `rem_q <= 16`.
  - A single-chunk descriptor gets both `sb_q` and `eb_q`.
- Address arithmetic is modulo 256; wrap-around is legal and carries no flag, e.g. 0xF8 + 16 → 0x08.
- `sched_flush`:
  - From any state, the next state is IDLE.
  - No `sched_done` pulse.
  - A `ctrl_ram_buff_vld` already registered for the current cycle still appears.
  - Flush wins over a simultaneous accept or completion.
- Only one descriptor is outstanding at a time; there is no queueing.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_rdy` = 1
  - `sched_busy` = 0, `sched_done` = 0
  - `ctrl_ram_buff_vld` = 0
  - all `ctrl_ram_buff_*` fields = 0
- Accept at cycle T → `ctrl_ram_buff_vld` at T+1, and `cmd_rdy` = 0 from T+1.
- Issue at cycle I → HOLD at I+1 → WAIT from I+2.
- `ram_buff_idle` high at WAIT cycle W:
  - next issue at W+1, or
  - `sched_done` at W+1.
- Zero-row descriptor: accept at T → `sched_done` at T+1 → `cmd_rdy` = 1 at T+2.
- Back-to-back descriptors: the earliest next accept is the cycle after `sched_done`.
- Ctrl fields are stable from the issue cycle until the next issue; they are only sampled while `vld` = 1.
- Reset asserted mid-operation: all state clears immediately (asynchronous) to the reset values above; no done pulse.

## Test plan
- Ascending 40 rows, addr 0x10, start_byte 3, end_byte 9, `ram_buff_idle` returning 5 cycles after each issue:
  - 3 pulses: addr 0x10/0x20/0x30, ent_num 15/15/7, ent_rng 0x0F/0x0F/0x07.
  - start_byte 3/0/0, end_byte F/F/9.
  - One `sched_done`.
- Descending 20 rows, addr 0x05:
  - Pulse 1: addr 0x05, ent_num 15, rng 0x11.
  - Pulse 2: addr 0xF5, ent_num 3, rng 0x1D.
  - Done after the second idle.
- `row_num` = 0: accepted, no ctrl pulse, `sched_done` one cycle after accept.
- Wrap-around: ascending 16 rows at 0xF8 then ascending 1 row at 0xF8 → single pulses, addr 0xF8, ent_num 15 / 0; the first wraps internally with no error.
- Holdoff: `ram_buff_idle` held at 1 throughout → each next issue is exactly 3 cycles after the previous one; never a pulse on consecutive cycles.
- Flush in WAIT mid-descriptor (after the 2nd of 3 chunks):
  - No further pulses, no `sched_done`, `cmd_rdy` = 1 next cycle.
  - A new descriptor then starts correctly with `first_q` set.
  - Repeat with rst_n dropped mid-WAIT → all outputs at reset values asynchronously.
